// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between NREQ requesters, with a completion watchdog.
// Optional macro DIV_ZERO_CHECK_EN answers divide-by-zero locally without starting the divider.
module div_arbiter #(
   parameter int unsigned W       = 32,
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req_valid,
   input  logic [NREQ*W-1:0] i_req_n,
   input  logic [NREQ*W-1:0] i_req_d,
   output logic [NREQ-1:0]   o_req_ready,
   output logic [NREQ-1:0]   o_resp_valid,
   output logic              o_resp_err,
   output logic [W-1:0]      o_resp_q,
   output logic [W-1:0]      o_resp_r,
   output logic              o_busy,
   output logic [W-1:0]      o_div_n,
   output logic [W-1:0]      o_div_d,
   output logic              o_div_start,
   input  logic [W-1:0]      i_div_q,
   input  logic [W-1:0]      i_div_r,
   input  logic              i_div_rdy
);
   localparam int unsigned    IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned    WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] TO_VAL  = WDW'(TIMEOUT);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   typedef enum logic [3:0] {
      StIdle  = 4'b0001,
      StIssue = 4'b0010,
      StWait  = 4'b0100,
      StResp  = 4'b1000
   } state_e;

   state_e          r_state;
   logic [IDW-1:0]  r_rr;
   logic [IDW-1:0]  r_gnt;
   logic [WDW-1:0]  r_wd;
   logic [NREQ-1:0] r_req_ready;
   logic [NREQ-1:0] r_resp_valid;
   logic            r_resp_err;
   logic [W-1:0]    r_resp_q;
   logic [W-1:0]    r_resp_r;
   logic [W-1:0]    r_div_n;
   logic [W-1:0]    r_div_d;
   logic            r_div_start;
`ifdef DIV_ZERO_CHECK_EN
   logic            r_dz;
`endif

   logic            w_found;
   logic [IDW-1:0]  w_pick;
   logic [W-1:0]    w_pick_n;
   logic [W-1:0]    w_pick_d;
   logic [WDW-1:0]  w_wd_inc;
   logic            w_timeout;
   logic [IDW-1:0]  w_rr_next;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      logic [IDW-1:0] v_idx;
      w_found = 1'b0;
      w_pick  = '0;
      v_idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         v_idx = IDW'((32'(r_rr) + k) % NREQ);
         if (!w_found && i_req_valid[v_idx]) begin
            w_found = 1'b1;
            w_pick  = v_idx;
         end
      end
   end

   assign w_pick_n  = i_req_n[32'(w_pick) * W +: W];
   assign w_pick_d  = i_req_d[32'(w_pick) * W +: W];
   assign w_wd_inc  = r_wd + 1'b1;
   assign w_timeout = (TIMEOUT != 0) && (w_wd_inc == TO_VAL);
   assign w_rr_next = (r_gnt == LAST_ID) ? '0 : r_gnt + 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_rr         <= '0;
         r_gnt        <= '0;
         r_wd         <= '0;
         r_req_ready  <= '0;
         r_resp_valid <= '0;
         r_resp_err   <= 1'b0;
         r_resp_q     <= '0;
         r_resp_r     <= '0;
         r_div_n      <= '0;
         r_div_d      <= '0;
         r_div_start  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
         r_dz         <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_gnt               <= w_pick;
                  r_div_n             <= w_pick_n;
                  r_div_d             <= w_pick_d;
                  r_req_ready[w_pick] <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                  r_dz                <= (w_pick_d == '0);
                  r_div_start         <= (w_pick_d != '0);
`else
                  r_div_start         <= 1'b1;
`endif
                  r_state             <= StIssue;
               end
            end
            StIssue: begin
               r_req_ready <= '0;
               r_div_start <= 1'b0;
               r_rr        <= w_rr_next;
               r_wd        <= '0;
`ifdef DIV_ZERO_CHECK_EN
               if (r_dz) begin
                  r_resp_q            <= '1;
                  r_resp_r            <= r_div_n;
                  r_resp_err          <= 1'b1;
                  r_resp_valid[r_gnt] <= 1'b1;
                  r_state             <= StResp;
               end else begin
                  r_state <= StWait;
               end
`else
               r_state     <= StWait;
`endif
            end
            StWait: begin
               // A completion on the same cycle as the timeout still counts as success.
               if (i_div_rdy) begin
                  r_resp_q            <= i_div_q;
                  r_resp_r            <= i_div_r;
                  r_resp_err          <= 1'b0;
                  r_resp_valid[r_gnt] <= 1'b1;
                  r_state             <= StResp;
               end else begin
                  r_wd <= w_wd_inc;
                  if (w_timeout) begin
                     r_resp_q            <= '1;
                     r_resp_r            <= r_div_n;
                     r_resp_err          <= 1'b1;
                     r_resp_valid[r_gnt] <= 1'b1;
                     r_state             <= StResp;
                  end
               end
            end
            StResp: begin
               r_resp_valid <= '0;
               r_state      <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_err   = r_resp_err;
   assign o_resp_q     = r_resp_q;
   assign o_resp_r     = r_resp_r;
   assign o_busy       = (r_state != StIdle);
   assign o_div_n      = r_div_n;
   assign o_div_d      = r_div_d;
   assign o_div_start  = r_div_start;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: predicted responses are queued at accept and popped by a
// response monitor; a behavioural divider with programmable latency sits on the DIV side.
module tb_div_arbiter;
   localparam int W       = 32;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 8;
`ifdef DIV_ZERO_CHECK_EN
   localparam bit ZCHK = 1'b1;
`else
   localparam bit ZCHK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_n, req_d;
   logic [NREQ-1:0]   req_ready, resp_valid;
   logic              resp_err, busy, div_start;
   logic [W-1:0]      resp_q, resp_r, div_n, div_d;
   logic [W-1:0]      div_q = '0;
   logic [W-1:0]      div_r = '0;
   logic              div_rdy = 1'b1;

   always #5 clk = ~clk;

   div_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_n(req_n), .i_req_d(req_d),
      .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_err(resp_err),
      .o_resp_q(resp_q), .o_resp_r(resp_r), .o_busy(busy), .o_div_n(div_n), .o_div_d(div_d),
      .o_div_start(div_start), .i_div_q(div_q), .i_div_r(div_r), .i_div_rdy(div_rdy)
   );

   typedef struct {
      int           id;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         err;
      int           t;
      int           dly;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   grants[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   ptr = 0;
   int   cyc = 0;
   int   cur_lat = 3;
   int   fixed_lat = 3;
   bit   hang = 1'b0;
   bit   rnd_mode = 1'b0;
   int   left[NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural divider: rdy drops after start, rises cur_lat cycles later unless hung.
   logic [W-1:0] m_n, m_d;
   int           m_cnt = 0;
   bit           m_busy = 1'b0;
   always @(posedge clk) begin
      if (div_start) begin
         div_rdy <= 1'b0;
         m_cnt   <= cur_lat;
         m_n     <= div_n;
         m_d     <= div_d;
         m_busy  <= 1'b1;
      end else if (m_busy && !hang) begin
         if (m_cnt <= 1) begin
            div_rdy <= 1'b1;
            div_q   <= (m_d == '0) ? '1 : m_n / m_d;
            div_r   <= (m_d == '0) ? m_n : m_n % m_d;
            m_busy  <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: grant is the first valid at or after ptr; response follows from the op and latency.
   task automatic accept_check();
      int           g;
      int           lat;
      bit           zc;
      exp_t         e;
      logic [W-1:0] n, d;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      end
      if (g < 0) begin
         chk("ready_without_valid", 64'(req_ready), 64'(0));
      end else begin
         chk("grant", 64'(req_ready), 64'(1) << g);
         n = req_n[g*W +: W];
         d = req_d[g*W +: W];
         chk("div_n", 64'(div_n), 64'(n));
         chk("div_d", 64'(div_d), 64'(d));
         chk("busy_issue", 64'(busy), 64'(1));
         lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(1, 10));
         cur_lat = lat;
         zc = ZCHK && (d == '0);
         chk("div_start", 64'(div_start), 64'(!zc));
         e.id = g;
         e.t  = cyc;
         if (zc) begin
            e.q = '1; e.r = n; e.err = 1'b1; e.dly = 1;
         end else if (hang || lat >= TIMEOUT) begin
            e.q = '1; e.r = n; e.err = 1'b1; e.dly = TIMEOUT + 1;
         end else begin
            e.q   = (d == '0) ? '1 : n / d;
            e.r   = (d == '0) ? n : n % d;
            e.err = 1'b0;
            e.dly = lat + 2;
         end
         exp_q.push_back(e);
         grants.push_back(g);
         ptr = (g + 1) % NREQ;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && resp_valid != '0) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_resp: resp_valid=%b with nothing outstanding", resp_valid);
         end else begin
            m_e = exp_q.pop_front();
            chk("resp_id", 64'(resp_valid), 64'(1) << m_e.id);
            chk("resp_q", 64'(resp_q), 64'(m_e.q));
            chk("resp_r", 64'(resp_r), 64'(m_e.r));
            chk("resp_err", 64'(resp_err), 64'(m_e.err));
            chk("resp_lat", 64'(cyc - m_e.t), 64'(m_e.dly));
         end
      end
   end

   function automatic logic [W-1:0] pick_d();
      int s;
      s = int'($urandom_range(0, 7));
      if (s == 0) return '0;
      else if (s < 3) return W'($urandom_range(1, 15));
      return W'($urandom);
   endfunction

   task automatic post(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
      req_n[i*W +: W] = n;
      req_d[i*W +: W] = d;
      req_valid[i]    = 1'b1;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) req_valid[i] = 1'b0;
         else if (req_valid[i] && rnd_mode && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
         if (!req_valid[i] && left[i] > 0 && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
            left[i]--;
            post(i, W'($urandom), pick_d());
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (!rst && req_ready != '0) accept_check();
      drive();
   endtask

   function automatic int pending();
      int s;
      s = exp_q.size() + int'(busy) + int'(req_valid != '0);
      for (int i = 0; i < NREQ; i++) s += left[i];
      return s;
   endfunction

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (pending() != 0 && k < budget) begin
         cycle();
         k++;
      end
      if (k >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d items still pending after %0d cycles", pending(), k);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
      chk({tag, "_resp_err"}, 64'(resp_err), 64'(0));
      chk({tag, "_resp_q"}, 64'(resp_q), 64'(0));
      chk({tag, "_resp_r"}, 64'(resp_r), 64'(0));
      chk({tag, "_div_n"}, 64'(div_n), 64'(0));
      chk({tag, "_div_d"}, 64'(div_d), 64'(0));
      chk({tag, "_div_start"}, 64'(div_start), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int k;
      int exp_g[4] = '{0, 1, 0, 1};
      rst = 1'b1;
      req_valid = '0;
      req_n = '0;
      req_d = '0;
      for (int i = 0; i < NREQ; i++) left[i] = 0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      cycle();

      // Single request on requester 0
      fixed_lat = 3;
      post(0, 32'd100, 32'd7);
      drain(200);
      chk("single_q", 64'(resp_q), 64'(14));
      chk("single_r", 64'(resp_r), 64'(2));
      chk("single_err", 64'(resp_err), 64'(0));

      // Divide by zero on requester 1 (also returns the pointer to 0)
      post(1, 32'd5, 32'd0);
      drain(200);
      chk("dz_r", 64'(resp_r), 64'(5));

      // Contention: both held, alternating grants
      grants.delete();
      fixed_lat = 2;
      post(0, 32'd1000, 32'd9);
      post(1, 32'd77, 32'd5);
      left[0] = 1;
      left[1] = 1;
      drain(300);
      chk("contention_cnt", 64'(grants.size()), 64'(4));
      for (int i = 0; i < 4 && i < grants.size(); i++) chk("contention_seq", 64'(grants[i]), 64'(exp_g[i]));

      // Divider never completes: watchdog error, then normal service
      hang = 1'b1;
      post(0, 32'd1234, 32'd10);
      drain(200);
      hang = 1'b0;
      chk("timeout_q", 64'(resp_q), 64'(32'hFFFF_FFFF));
      fixed_lat = 1;
      post(1, 32'd50, 32'd6);
      drain(200);

      // Completion on the last watchdog cycle, then one cycle too late
      fixed_lat = TIMEOUT - 1;
      post(0, 32'd999, 32'd4);
      drain(200);
      chk("edge_err", 64'(resp_err), 64'(0));
      fixed_lat = TIMEOUT;
      post(1, 32'd999, 32'd4);
      drain(200);

      // Reset during WAIT: result is lost, pointer returns to 0
      fixed_lat = 20;
      post(0, 32'd1000, 32'd3);
      k = 0;
      while (req_ready[0] !== 1'b1 && k < 20) begin
         cycle();
         k++;
      end
      chk("rst_setup_accept", 64'(k < 20), 64'(1));
      repeat (4) cycle();
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete();
      ptr = 0;
      check_reset_values("midwait_rst");
      rst = 1'b0;
      repeat (25) cycle();
      check_reset_values("after_rst");
      fixed_lat = 2;
      post(0, 32'd31, 32'd3);
      post(1, 32'd32, 32'd3);
      drain(300);

      // Randomised traffic
      rnd_mode = 1'b1;
      fixed_lat = -1;
      for (int i = 0; i < NREQ; i++) left[i] = 40;
      drain(8000);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not reach its summary");
      $fatal(1);
   end

endmodule
